lift_call_scheduler: RTL and testbench
======================================

# lift_call_scheduler

Call scheduler for the single-car `Lift` datapath. It latches hall calls (`pass_f`) and car calls (`butt_el`) into a per-floor pending register and picks the next target floor with a SCAN (direction-preserving) policy. It hands that target to the lift over a valid/busy handshake and clears each call once the car has stopped at its floor. It sits between the floor/car button logic and `Lift`.

## Interface
- `NUM_FLOORS`, 8: floors 0..NUM_FLOORS-1; max 8.
- `FLOOR_W`, 3: floor code width.
- `DWELL_CYC`, 16: door dwell, in clk cycles, after each stop.
- `PARK_CYC`, 64: idle cycles before a park move (`LIFT_PARK_EN` only).
- `PARK_F`, 1: park floor (`LIFT_PARK_EN` only).
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pass_f`  in  FLOOR_W  hall call floor code; 0 = no press.
- `butt_el`  in  FLOOR_W  car button floor code; 0 = no press.
- `elev_f_i`  in  FLOOR_W  current car floor (from `Lift` `elev_f_o`).
- `lift_busy_i`  in  1  car moving (from `Lift` `busy_o`).
- `target_f_o`  out  FLOOR_W  floor issued to `Lift`.
- `target_vld_o`  out  1  `target_f_o` valid.
- `pending_o`  out  NUM_FLOORS  pending-call bitmap.
- `dir_o`  out  1  travel direction; 1 = up, 0 = down.
- `sched_busy_o`  out  1  state ≠ IDLE or any call pending.

## Operation
- **Call capture**
  - A nonzero code below NUM_FLOORS sets `pending[code]`. Codes ≥ NUM_FLOORS are ignored.
  - Capture runs in every state.
  - Hall and car calls in the same cycle both set their bits. If both name the same floor, that floor gets one bit.
- **States:** IDLE, SELECT, ISSUE, MOVE, DWELL.
- **IDLE**
  - Go to SELECT when `pending` ≠ 0.
- **SELECT** (1 cycle)
  - If `pending[elev_f_i]` is set: clear it and go to DWELL. No issue is made.
  - Else if dir = up: pick the nearest set bit above `elev_f_i`. If there is none, set dir = down and pick the nearest set bit below.
  - Else (dir = down): the same rule, mirrored.
  - Register the pick into `target_f_o`, then go to ISSUE.
  - If nothing is pending, return to IDLE.
- **ISSUE**
  - `target_vld_o` = 1 and `target_f_o` is held stable.
  - Go to MOVE on the first cycle `lift_busy_i` = 1 (accept).
- **MOVE**
  - `target_vld_o` = 0.
  - On the first cycle `lift_busy_i` = 0: clear `pending[elev_f_i]` and go to DWELL.
- **DWELL**
  - The counter loads DWELL_CYC−1 on entry and counts down; at 0 go to SELECT.
  - A new call for `elev_f_i` during DWELL is cleared in the same cycle it arrives and reloads the counter (door reopen).
- **Passing calls**
  - A call set for the current target while in MOVE stays set and is cleared at arrival.
  - No retargeting happens mid-move. Intermediate calls are served on the next SELECT.
- **Floor 0**
  - Not requestable, because code 0 means no press. Floor 0 is never a target except through PARK_F = 0.

## Timing
- **Reset values:** state IDLE; `pending` 0; `target_f_o` 0; `target_vld_o` 0; `dir_o` 1; `sched_busy_o` 0; dwell and park counters 0.
- **Reset mid-operation:** all state is discarded immediately and asynchronously. Any outstanding issue is dropped.
- **Latency, call to issue:**
  - Call registered at edge N; bit visible in `pending_o` after N.
  - IDLE→SELECT at N+1, ISSUE at N+2, so `target_vld_o` is high after edge N+2.
- **Handshake:**
  - `target_vld_o` stays high until `lift_busy_i` is sampled high. It never drops without an accept.
  - `target_f_o` changes only in SELECT.
- **End-of-travel:** at the top (or bottom) floor with nothing beyond it, dir reverses in the same SELECT cycle. There is no wrap-around.

## Configuration
- `LIFT_PARK_EN` defined:
  - In IDLE with `pending` = 0 and `elev_f_i` ≠ PARK_F, the park counter increments.
  - At PARK_CYC, set `pending[PARK_F]`, so parking is a normal call.
  - Any call resets the counter.
- `LIFT_PARK_EN` undefined:
  - No park counter; the car stays at its last floor indefinitely.
  - PARK_CYC and PARK_F are unused.

## Structure
- Package `lift_pkg` holds:
  - `FLOOR_W` and `NUM_FLOORS` defaults;
  - the state enum `sched_state_t`;
  - `DIR_UP` = 1 and `DIR_DOWN` = 0.
- Sub-module `lift_scan_pick`:
  - Purely combinational.
  - Inputs: pending bitmap, current floor, dir.
  - Outputs: found flag, picked floor, new dir.
  - The priority search is isolated here so it can be tested alone.

## Test plan
- Reset, then `pass_f`=3 for 1 cycle with `elev_f_i`=0 → `pending_o`=8'h08; `target_vld_o`=1, `target_f_o`=3 two cycles later; held until `lift_busy_i`=1.
- Car at 3, dir up, `pending` has bits {1,7} → target 7. After arrival and dwell → dir_o=0, target 1.
- `pass_f`=5 and `butt_el`=5 in the same cycle → `pending_o`=8'h20, exactly one issue.
- Call for `elev_f_i` during DWELL → bit never visible after that cycle; dwell restarts (DWELL_CYC more cycles).
- `rst_n` low during MOVE with `pending`=8'hA4 → all outputs at reset values within the reset assertion; no issue after release.
- With `LIFT_PARK_EN`, idle at floor 6 for PARK_CYC cycles → target 1 issued. Without the macro → no issue after 2×PARK_CYC.

Source files
------------

// File: rtl/lift_pkg.sv
// lift_pkg: shared floor defaults, scheduler states and direction codes for the lift call scheduler.
package lift_pkg;
    localparam int NUM_FLOORS_DEF = 8;
    localparam int FLOOR_W_DEF = 3;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
    typedef enum logic [2:0] {IDLE, SELECT, ISSUE, MOVE, DWELL} sched_state_t;
endpackage

// File: rtl/lift_scan_pick.sv
// lift_scan_pick: combinational SCAN search for the nearest pending floor, preferring the current direction.
module lift_scan_pick import lift_pkg::*; #(
    parameter int NUM_FLOORS = NUM_FLOORS_DEF,
    parameter int FLOOR_W = FLOOR_W_DEF
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur,
    input  logic                  dir,
    output logic                  found,
    output logic [FLOOR_W-1:0]    pick,
    output logic                  dir_new
);
    logic up_ok, dn_ok, take_up;
    logic [FLOOR_W-1:0] up_f, dn_f;
    always_comb begin
        up_ok = 1'b0;
        dn_ok = 1'b0;
        up_f = '0;
        dn_f = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--)
            if (i > int'(cur) && pending[i]) begin
                up_ok = 1'b1;
                up_f = FLOOR_W'(i);
            end
        for (int i = 0; i < NUM_FLOORS; i++)
            if (i < int'(cur) && pending[i]) begin
                dn_ok = 1'b1;
                dn_f = FLOOR_W'(i);
            end
    end
    // Reverse only when nothing remains ahead in the current direction.
    assign take_up = up_ok && (dir == DIR_UP || !dn_ok);
    assign found = up_ok || dn_ok;
    assign pick = take_up ? up_f : dn_f;
    assign dir_new = found ? (take_up ? DIR_UP : DIR_DOWN) : dir;
endmodule

// File: rtl/lift_call_scheduler.sv
// lift_call_scheduler: SCAN call scheduler feeding Lift over valid/busy; LIFT_PARK_EN adds idle parking at PARK_F.
module lift_call_scheduler import lift_pkg::*; #(
    parameter int NUM_FLOORS = NUM_FLOORS_DEF,
    parameter int FLOOR_W = FLOOR_W_DEF,
    parameter int DWELL_CYC = 16
`ifdef LIFT_PARK_EN
    ,
    parameter int PARK_CYC = 64,
    parameter int PARK_F = 1
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FLOOR_W-1:0]    pass_f,
    input  logic [FLOOR_W-1:0]    butt_el,
    input  logic [FLOOR_W-1:0]    elev_f_i,
    input  logic                  lift_busy_i,
    output logic [FLOOR_W-1:0]    target_f_o,
    output logic                  target_vld_o,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic                  dir_o,
    output logic                  sched_busy_o
);
    localparam int DW = $clog2(DWELL_CYC + 1);
    sched_state_t state, state_nxt;
    logic [NUM_FLOORS-1:0] pending, pend_nxt, call_set, here, park_set;
    logic [FLOOR_W-1:0] tgt_nxt, pick_f;
    logic dir, dir_nxt, found, pick_dir, reopen;
    logic [DW-1:0] dwell, dwell_nxt;

    function automatic logic [NUM_FLOORS-1:0] code_bit(input logic [FLOOR_W-1:0] code);
        return (code != '0 && 32'(code) < NUM_FLOORS) ? NUM_FLOORS'(1) << code : '0;
    endfunction

    assign call_set = code_bit(pass_f) | code_bit(butt_el);
    assign here = NUM_FLOORS'(1) << elev_f_i;
    assign reopen = state == DWELL && (call_set & here) != '0;

`ifdef LIFT_PARK_EN
    localparam int PW = $clog2(PARK_CYC + 1);
    logic [PW-1:0] park_cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            park_cnt <= '0;
        else if (call_set != '0 || state != IDLE || pending != '0 || 32'(elev_f_i) == PARK_F || 32'(park_cnt) == PARK_CYC)
            park_cnt <= '0;
        else
            park_cnt <= park_cnt + 1'b1;
    assign park_set = 32'(park_cnt) == PARK_CYC ? NUM_FLOORS'(1) << PARK_F : '0;
`else
    assign park_set = '0;
`endif

    lift_scan_pick #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_pick (
        .pending(pending),
        .cur(elev_f_i),
        .dir(dir),
        .found(found),
        .pick(pick_f),
        .dir_new(pick_dir)
    );

    always_comb begin
        state_nxt = state;
        tgt_nxt = target_f_o;
        dir_nxt = dir;
        dwell_nxt = dwell;
        pend_nxt = pending | call_set | park_set;
        case (state)
            IDLE: state_nxt = pending != '0 ? SELECT : IDLE;
            SELECT: begin
                if ((pending & here) != '0) begin
                    pend_nxt = pend_nxt & ~here;
                    dwell_nxt = DW'(DWELL_CYC - 1);
                    state_nxt = DWELL;
                end else if (found) begin
                    tgt_nxt = pick_f;
                    dir_nxt = pick_dir;
                    state_nxt = ISSUE;
                end else
                    state_nxt = IDLE;
            end
            ISSUE: state_nxt = lift_busy_i ? MOVE : ISSUE;
            MOVE: begin
                if (!lift_busy_i) begin
                    pend_nxt = pend_nxt & ~here;
                    dwell_nxt = DW'(DWELL_CYC - 1);
                    state_nxt = DWELL;
                end
            end
            DWELL: begin
                // Doors are open here, so a call for this floor is served instantly and reopens them.
                pend_nxt = pend_nxt & ~here;
                dwell_nxt = reopen ? DW'(DWELL_CYC - 1) : dwell - 1'b1;
                state_nxt = !reopen && dwell == '0 ? SELECT : DWELL;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            pending <= '0;
            target_f_o <= '0;
            dir <= DIR_UP;
            dwell <= '0;
        end else begin
            state <= state_nxt;
            pending <= pend_nxt;
            target_f_o <= tgt_nxt;
            dir <= dir_nxt;
            dwell <= dwell_nxt;
        end

    assign target_vld_o = state == ISSUE;
    assign pending_o = pending;
    assign dir_o = dir;
    assign sched_busy_o = state != IDLE || pending != '0;
endmodule

// File: tb/tb_lift_call_scheduler.sv
// tb_lift_call_scheduler: directed calls and lift responses, checked every cycle against a behavioural SCAN model plus literal pins.
module tb_lift_call_scheduler;
    localparam int NF = 8;
    localparam int DWELL = 16;
    localparam int PARK = 64;
    localparam int PF = 1;
    localparam int P_IDLE = 0, P_PICK = 1, P_OFFER = 2, P_RIDE = 3, P_DOOR = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] pass_f = '0, butt_el = '0, elev_f_i = '0;
    logic lift_busy_i = 1'b0;
    logic [2:0] target_f_o;
    logic target_vld_o, dir_o, sched_busy_o;
    logic [7:0] pending_o;
    int total = 0, bad = 0, issues = 0, i0 = 0;
    bit prev_vld = 1'b0;

    lift_call_scheduler dut (
        .clk(clk),
        .rst_n(rst_n),
        .pass_f(pass_f),
        .butt_el(butt_el),
        .elev_f_i(elev_f_i),
        .lift_busy_i(lift_busy_i),
        .target_f_o(target_f_o),
        .target_vld_o(target_vld_o),
        .pending_o(pending_o),
        .dir_o(dir_o),
        .sched_busy_o(sched_busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [7:0] pend;
        int ph;
        int tgt;
        bit dir;
        int door;
        int idle;
    } mdl_t;

    function automatic mdl_t m0();
        mdl_t r = '{pend: 8'h00, ph: P_IDLE, tgt: 0, dir: 1'b1, door: 0, idle: 0};
        return r;
    endfunction

    function automatic bit [7:0] req(input logic [2:0] code);
        return (code != 3'd0 && int'(code) < NF) ? 8'(1) << code : 8'h00;
    endfunction

    // One clock of the scheduler as described: served floor cleared, nearest call ahead, else turn around.
    function automatic mdl_t step(input mdl_t s, input logic [2:0] pf, input logic [2:0] bf, input logic [2:0] fl, input logic busy);
        mdl_t n = s;
        int f = int'(fl);
        bit [7:0] here = 8'(1) << fl;
        bit [7:0] calls = req(pf) | req(bf);
        int up = -1, dn = -1;
        n.pend = s.pend | calls;
        case (s.ph)
            P_IDLE: if (s.pend != 0) n.ph = P_PICK;
            P_PICK: begin
                if (s.pend[f]) begin
                    n.pend = n.pend & ~here;
                    n.door = 0;
                    n.ph = P_DOOR;
                end else begin
                    for (int d = NF - 1; d >= 1; d--) begin
                        if (f + d < NF && s.pend[f + d]) up = f + d;
                        if (f - d >= 0 && s.pend[f - d]) dn = f - d;
                    end
                    if (up < 0 && dn < 0) n.ph = P_IDLE;
                    else begin
                        n.dir = s.dir ? (up >= 0) : (dn < 0);
                        n.tgt = n.dir ? up : dn;
                        n.ph = P_OFFER;
                    end
                end
            end
            P_OFFER: if (busy) n.ph = P_RIDE;
            P_RIDE: if (!busy) begin
                n.pend = n.pend & ~here;
                n.door = 0;
                n.ph = P_DOOR;
            end
            P_DOOR: begin
                n.pend = n.pend & ~here;
                if ((calls & here) != 0) n.door = 0;
                else if (s.door == DWELL - 1) n.ph = P_PICK;
                else n.door = s.door + 1;
            end
            default: n.ph = P_IDLE;
        endcase
`ifdef LIFT_PARK_EN
        if (calls != 0 || s.ph != P_IDLE || s.pend != 0 || f == PF || s.idle == PARK) n.idle = 0;
        else n.idle = s.idle + 1;
        if (s.idle == PARK) n.pend[PF] = 1'b1;
`endif
        return n;
    endfunction

    mdl_t m = m0();

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m <= m0();
        else m <= step(m, pass_f, butt_el, elev_f_i, lift_busy_i);

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_vld", int'(target_vld_o), int'(m.ph == P_OFFER));
        chk("m_tgt", int'(target_f_o), m.tgt);
        chk("m_pend", int'(pending_o), int'(m.pend));
        chk("m_dir", int'(dir_o), int'(m.dir));
        chk("m_sbusy", int'(sched_busy_o), int'(m.ph != P_IDLE || m.pend != 0));
        if (target_vld_o && !prev_vld) issues++;
        prev_vld = target_vld_o;
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ride(input logic [2:0] dest);
        lift_busy_i = 1'b1;
        cyc();
        cyc(2);
        elev_f_i = dest;
        lift_busy_i = 1'b0;
        cyc();
    endtask

    initial begin
        cyc(3);
        chk("rst_pend", int'(pending_o), 0);
        chk("rst_vld", int'(target_vld_o), 0);
        chk("rst_tgt", int'(target_f_o), 0);
        chk("rst_dir", int'(dir_o), 1);
        chk("rst_sbusy", int'(sched_busy_o), 0);
        rst_n = 1'b1;
        cyc(2);
        // single hall call from floor 0
        pass_f = 3'd3;
        cyc();
        pass_f = 3'd0;
        chk("t1_pend", int'(pending_o), 8'h08);
        chk("t1_vld_n", int'(target_vld_o), 0);
        cyc();
        chk("t1_vld_n1", int'(target_vld_o), 0);
        chk("t1_sbusy", int'(sched_busy_o), 1);
        cyc();
        chk("t1_vld", int'(target_vld_o), 1);
        chk("t1_tgt", int'(target_f_o), 3);
        cyc(3);
        chk("t1_hold_vld", int'(target_vld_o), 1);
        chk("t1_hold_tgt", int'(target_f_o), 3);
        ride(3'd3);
        chk("t1_arrive_pend", int'(pending_o), 0);
        cyc(DWELL + 3);
        chk("t1_idle", int'(sched_busy_o), 0);
        // SCAN: up to 7 first, then reverse to 1
        pass_f = 3'd1;
        butt_el = 3'd7;
        cyc();
        pass_f = 3'd0;
        butt_el = 3'd0;
        chk("t2_pend", int'(pending_o), 8'h82);
        cyc(2);
        chk("t2_vld", int'(target_vld_o), 1);
        chk("t2_tgt", int'(target_f_o), 7);
        ride(3'd7);
        chk("t2_pend2", int'(pending_o), 8'h02);
        chk("t2_dir", int'(dir_o), 1);
        cyc(DWELL);
        chk("t2_dwell_vld", int'(target_vld_o), 0);
        cyc();
        chk("t2_rev_vld", int'(target_vld_o), 1);
        chk("t2_rev_tgt", int'(target_f_o), 1);
        chk("t2_rev_dir", int'(dir_o), 0);
        ride(3'd1);
        cyc(DWELL + 3);
        chk("t2_idle", int'(sched_busy_o), 0);
        // same floor from hall and car in one cycle
        i0 = issues;
        pass_f = 3'd5;
        butt_el = 3'd5;
        cyc();
        pass_f = 3'd0;
        butt_el = 3'd0;
        chk("t3_pend", int'(pending_o), 8'h20);
        cyc(2);
        chk("t3_tgt", int'(target_f_o), 5);
        chk("t3_dir", int'(dir_o), 1);
        ride(3'd5);
        // door reopen during dwell
        cyc(5);
        pass_f = 3'd5;
        cyc();
        pass_f = 3'd0;
        chk("t4_clear", int'(pending_o), 0);
        cyc(DWELL - 1);
        chk("t4_still_dwell", int'(sched_busy_o), 1);
        cyc();
        chk("t4_select", int'(sched_busy_o), 1);
        cyc();
        chk("t4_idle", int'(sched_busy_o), 0);
        chk("t3_one_issue", issues - i0, 1);
        // reset while moving with 8'hA4 pending
        i0 = issues;
        pass_f = 3'd2;
        butt_el = 3'd7;
        cyc();
        pass_f = 3'd0;
        butt_el = 3'd0;
        cyc(2);
        chk("t5_tgt", int'(target_f_o), 7);
        lift_busy_i = 1'b1;
        cyc();
        elev_f_i = 3'd6;
        pass_f = 3'd5;
        cyc();
        pass_f = 3'd0;
        chk("t5_pend", int'(pending_o), 8'hA4);
        chk("t5_move_vld", int'(target_vld_o), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_pend", int'(pending_o), 0);
        chk("t5_rst_vld", int'(target_vld_o), 0);
        chk("t5_rst_tgt", int'(target_f_o), 0);
        chk("t5_rst_dir", int'(dir_o), 1);
        chk("t5_rst_sbusy", int'(sched_busy_o), 0);
        cyc(3);
        lift_busy_i = 1'b0;
        rst_n = 1'b1;
        cyc(20);
        chk("t5_no_issue", issues - i0, 1);
        chk("t5_vld", int'(target_vld_o), 0);
        // idle at floor 6: parking only with the feature enabled
        i0 = issues;
`ifdef LIFT_PARK_EN
        for (int i = 0; i < 2 * PARK && !target_vld_o; i++) cyc();
        chk("t6_park_vld", int'(target_vld_o), 1);
        chk("t6_park_tgt", int'(target_f_o), PF);
        ride(3'd1);
        cyc(DWELL + 3);
`else
        cyc(2 * PARK);
        chk("t6_no_park", issues - i0, 0);
        chk("t6_pend", int'(pending_o), 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
